// File: rtl/ps2_pkg.sv
// Shared types and PS/2 protocol byte constants for the host command sequencer.
package ps2_pkg;

  typedef enum logic [2:0] {
    INIT_SEND,
    SEND,
    WAIT_TX,
    WAIT_ACK,
    WAIT_BAT,
    WAIT_ID,
    IDLE,
    FAIL_INIT
  } ps2_state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_NAK     = 2'd1,
    STAT_ERR     = 2'd2,
    STAT_TIMEOUT = 2'd3
  } ps2_status_t;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ERROR    = 8'hFC;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_MOUSE_ID = 8'h00;

endpackage

// File: rtl/ps2_timeout.sv
// Loadable down-counter used as the response/transmit watchdog.
// expire is raised in the last cycle of the window, so a caller that
// registers on it reacts exactly CYCLES cycles after the load edge.
module ps2_timeout #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down while enabled, saturating at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Staying asserted at zero keeps the window closed if a caller lingers.
  assign expire = en && (cnt_q <= W'(1));

endmodule

// File: rtl/ps2_cmd_seq.sv
// Host-side PS/2 command sequencer: power-up mouse init, host command
// serialisation with ACK/RESEND/ERROR handling, retries, timeouts and
// forwarding of unsolicited device bytes.
module ps2_cmd_seq
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter bit          INIT_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       tx_wr,
  output logic [7:0] tx_din,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       rsp_valid,
  output logic [1:0] rsp_status,
  output logic       stream_valid,
  output logic [7:0] stream_byte,
  output logic       init_done,
  output logic       init_fail
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  ps2_state_t  state_q, state_d;
  ps2_status_t rsp_status_q, rsp_status_d, fail_code;
  logic [7:0]  tx_din_q, tx_din_d;
  logic [7:0]  stream_byte_q, stream_byte_d;
  logic [7:0]  arg_q, arg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] init_retry_q, init_retry_d;
  logic rsp_valid_q, rsp_valid_d;
  logic stream_valid_q, stream_valid_d;
  logic init_done_q, init_done_d;
  logic init_fail_q, init_fail_d;
  logic in_init_q, in_init_d;
  logic init_step_q, init_step_d;
  logic arg_phase_q, arg_phase_d;
  logic has_arg_q, has_arg_d;
  logic tmr_load, tmr_en, tmr_expire;
  logic fail_req;

  ps2_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  assign tmr_en = (state_q == WAIT_TX) || (state_q == WAIT_ACK) ||
                  (state_q == WAIT_BAT) || (state_q == WAIT_ID);

  assign cmd_ready    = (state_q == IDLE) && (init_done_q || init_fail_q);
  assign tx_din       = tx_din_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_status   = rsp_status_q;
  assign stream_valid = stream_valid_q;
  assign stream_byte  = stream_byte_q;
  assign init_done    = init_done_q;
  assign init_fail    = init_fail_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= INIT_EN ? INIT_SEND : IDLE;
      rsp_status_q   <= STAT_OK;
      tx_din_q       <= '0;
      stream_byte_q  <= '0;
      arg_q          <= '0;
      retry_q        <= '0;
      init_retry_q   <= '0;
      rsp_valid_q    <= 1'b0;
      stream_valid_q <= 1'b0;
      init_done_q    <= !INIT_EN;
      init_fail_q    <= 1'b0;
      in_init_q      <= INIT_EN;
      init_step_q    <= 1'b0;
      arg_phase_q    <= 1'b0;
      has_arg_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rsp_status_q   <= rsp_status_d;
      tx_din_q       <= tx_din_d;
      stream_byte_q  <= stream_byte_d;
      arg_q          <= arg_d;
      retry_q        <= retry_d;
      init_retry_q   <= init_retry_d;
      rsp_valid_q    <= rsp_valid_d;
      stream_valid_q <= stream_valid_d;
      init_done_q    <= init_done_d;
      init_fail_q    <= init_fail_d;
      in_init_q      <= in_init_d;
      init_step_q    <= init_step_d;
      arg_phase_q    <= arg_phase_d;
      has_arg_q      <= has_arg_d;
    end
  end

  // Next-state and output decode; every failure funnels through fail_req so
  // init errors restart the program while host errors end with a response.
  always_comb begin
    state_d        = state_q;
    rsp_status_d   = rsp_status_q;
    tx_din_d       = tx_din_q;
    stream_byte_d  = stream_byte_q;
    arg_d          = arg_q;
    retry_d        = retry_q;
    init_retry_d   = init_retry_q;
    rsp_valid_d    = 1'b0;
    stream_valid_d = 1'b0;
    init_done_d    = init_done_q;
    init_fail_d    = init_fail_q;
    in_init_d      = in_init_q;
    init_step_d    = init_step_q;
    arg_phase_d    = arg_phase_q;
    has_arg_d      = has_arg_q;
    tx_wr          = 1'b0;
    tmr_load       = 1'b0;
    fail_req       = 1'b0;
    fail_code      = STAT_OK;

    unique case (state_q)
      INIT_SEND: begin
        tx_din_d  = init_step_q ? PS2_ENABLE : PS2_RESET;
        retry_d   = '0;
        in_init_d = 1'b1;
        state_d   = SEND;
      end

      SEND: begin
        if (tx_idle) begin
          tx_wr    = 1'b1;
          tmr_load = 1'b1;
          state_d  = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (tx_done_tick) begin
          tmr_load = 1'b1;
          state_d  = WAIT_ACK;
        end else if (tmr_expire) begin
          fail_req  = 1'b1;
          fail_code = STAT_TIMEOUT;
        end
      end

      WAIT_ACK: begin
        if (rx_done_tick) begin
          if (rx_dout == PS2_ACK) begin
            if (in_init_q) begin
              if (!init_step_q) begin
                tmr_load = 1'b1;
                state_d  = WAIT_BAT;
              end else begin
                init_done_d = 1'b1;
                in_init_d   = 1'b0;
                state_d     = IDLE;
              end
            end else if (has_arg_q && !arg_phase_q) begin
              arg_phase_d = 1'b1;
              tx_din_d    = arg_q;
              retry_d     = '0;
              state_d     = SEND;
            end else begin
              rsp_valid_d  = 1'b1;
              rsp_status_d = STAT_OK;
              state_d      = IDLE;
            end
          end else if (rx_dout == PS2_RESEND) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + RW'(1);
              state_d = SEND;
            end else begin
              fail_req  = 1'b1;
              fail_code = STAT_NAK;
            end
          end else if (rx_dout == PS2_ERROR) begin
            fail_req  = 1'b1;
            fail_code = STAT_ERR;
          end else if (!in_init_q) begin
            stream_valid_d = 1'b1;
            stream_byte_d  = rx_dout;
          end
        end else if (tmr_expire) begin
          fail_req  = 1'b1;
          fail_code = STAT_TIMEOUT;
        end
      end

      WAIT_BAT: begin
        if (rx_done_tick) begin
          if (rx_dout == PS2_BAT_OK) begin
            tmr_load = 1'b1;
            state_d  = WAIT_ID;
          end else begin
            fail_req  = 1'b1;
            fail_code = STAT_ERR;
          end
        end else if (tmr_expire) begin
          fail_req  = 1'b1;
          fail_code = STAT_TIMEOUT;
        end
      end

      WAIT_ID: begin
        if (rx_done_tick) begin
          if (rx_dout == PS2_MOUSE_ID) begin
            init_step_d = 1'b1;
            state_d     = INIT_SEND;
          end else begin
            fail_req  = 1'b1;
            fail_code = STAT_ERR;
          end
        end else if (tmr_expire) begin
          fail_req  = 1'b1;
          fail_code = STAT_TIMEOUT;
        end
      end

      IDLE: begin
        if (rx_done_tick) begin
          stream_valid_d = 1'b1;
          stream_byte_d  = rx_dout;
        end
        if (cmd_valid && cmd_ready) begin
          tx_din_d    = cmd_byte;
          has_arg_d   = cmd_has_arg;
          arg_d       = cmd_arg;
          arg_phase_d = 1'b0;
          retry_d     = '0;
          in_init_d   = 1'b0;
          state_d     = SEND;
        end
      end

      FAIL_INIT: begin
        if (init_retry_q < RW'(MAX_RETRY)) begin
          init_retry_d = init_retry_q + RW'(1);
          init_step_d  = 1'b0;
          state_d      = INIT_SEND;
        end else begin
          init_fail_d = 1'b1;
          in_init_d   = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase

    if (fail_req) begin
      if (in_init_q) begin
        state_d = FAIL_INIT;
      end else begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = fail_code;
        state_d      = IDLE;
      end
    end
  end

endmodule

// File: doc/ps2_cmd_seq.md
# ps2_cmd_seq

Host-side command sequencer for the PS/2 port; the block that drives the transmitter's write strobe and data byte and the receiver's byte stream. Runs a power-up mouse init sequence (reset, self-test, enable streaming). Then serialises host commands with optional argument bytes, checks device ACK/RESEND/ERROR responses with retry and timeout, and forwards all unsolicited device bytes to a stream port. Sits between the PS/2 tx/rx pair and the rest of the design.

## Interface
- TIMEOUT_CYCLES, 2000000: cycles allowed for tx completion or for a device response byte.
- MAX_RETRY, 3: resends allowed per byte on 0xFE.
- INIT_EN, 1: 1 = run init sequence after reset; 0 = go directly to IDLE with init_done=1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_byte  in  8  command byte.
- cmd_has_arg  in  1  command carries an argument byte.
- cmd_arg  in  8  argument byte.
- tx_wr  out  1  one-cycle write strobe to the transmitter.
- tx_din  out  8  byte to transmit; stable while not IDLE.
- tx_idle  in  1  transmitter idle.
- tx_done_tick  in  1  transmitter finished frame.
- rx_done_tick  in  1  receiver byte valid (1 cycle).
- rx_dout  in  8  received byte.
- rsp_valid  out  1  one-cycle pulse: host command complete.
- rsp_status  out  2  completion status, valid with rsp_valid.
- stream_valid  out  1  one-cycle pulse: unsolicited byte.
- stream_byte  out  8  unsolicited byte.
- init_done  out  1  init sequence succeeded (sticky).
- init_fail  out  1  init sequence failed after retries (sticky).

## Operation
- States: INIT_SEND, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, IDLE, FAIL_INIT.
- Init program: send 0xFF → ACK → wait 0xAA (WAIT_BAT) → wait 0x00 (WAIT_ID) → send 0xF4 → ACK → init_done=1, IDLE.
- Init error (NAK/ERR/timeout on any step, or wrong BAT/ID byte): restart whole program. A restart counter (≤ MAX_RETRY) is compared before restarting. Exhausted → init_fail=1, IDLE.
- Host command: accepted only in IDLE; latches cmd_byte, cmd_has_arg, cmd_arg. Send cmd_byte, wait ACK. If cmd_has_arg, send cmd_arg, wait ACK. Then rsp_valid with OK.
- SEND: assert tx_wr for exactly one cycle when tx_idle=1, then go to WAIT_TX. If tx_idle=0, hold in SEND with no timeout.
- WAIT_TX: tx_done_tick → WAIT_ACK.
- WAIT_ACK response bytes:
  - 0xFA: advance.
  - 0xFE: resend same byte if retry count < MAX_RETRY; otherwise status NAK.
  - 0xFC: status ERR.
  - Any other byte: forwarded on stream port; keep waiting.
- Status codes: OK=0, NAK=1, ERR=2, TIMEOUT=3. A failing host command ends with rsp_valid and that status, then IDLE. The argument byte is not sent after a failed command byte.
- Retry count resets per byte. Timeout counter reloads on entry to WAIT_TX, WAIT_ACK, WAIT_BAT and WAIT_ID.
- In IDLE, every rx byte → stream_valid/stream_byte. During init, rx bytes other than the expected ones are not forwarded.

## Timing
- Reset (async, reset_n=0):
  - All outputs 0: cmd_ready, tx_wr, tx_din, rsp_valid, rsp_status, stream_valid, stream_byte, init_done, init_fail.
  - State → INIT_SEND, or IDLE if INIT_EN=0.
- Reset mid-frame: sequencer restarts cleanly. The transmitter is reset by the same signal.
- cmd_ready = (state==IDLE) & (init_done|init_fail), registered-free decode.
- Accept at cycle N → tx_wr at N+1 if tx_idle.
- tx_wr never asserts while tx_idle=0.
- rx byte at cycle N → stream_valid at N+1. Same latency for rsp_valid after the final ACK.
- Timeout: expires after TIMEOUT_CYCLES cycles in a wait state. If rx_done_tick coincides with expiry, the byte wins.
- A cmd_valid arriving in the same cycle a stream byte is forwarded is still accepted.
- Counter widths: $clog2(TIMEOUT_CYCLES+1), $clog2(MAX_RETRY+1). No wraparound; saturate at 0.

## Structure
- Package ps2_pkg holds:
  - state enum;
  - status enum (OK/NAK/ERR/TIMEOUT);
  - PS/2 byte constants: ACK 0xFA, RESEND 0xFE, ERROR 0xFC, BAT_OK 0xAA, RESET 0xFF, ENABLE 0xF4, MOUSE_ID 0x00.
- One sub-module, ps2_timeout: loadable down-counter with expire flag.
- Top-level wrapper instantiates ps2_cmd_seq with the tx/rx pair; that wrapper is not part of this block.

## Test plan
- Init happy path: model replies FA, AA, 00 to 0xFF, then FA to 0xF4 → init_done=1, two tx_wr pulses (0xFF, 0xF4), no stream output.
- Command with arg: 0xF3/arg 0x64, both ACKed FA → tx_din 0xF3 then 0x64, rsp_valid with OK.
- Resend exhaustion: MAX_RETRY=3, device answers FE every time → 4 transmissions of the same byte, then rsp_status NAK, arg not sent.
- Timeout: no reply after tx_done_tick, TIMEOUT_CYCLES=100 → rsp_valid with TIMEOUT exactly 100 cycles after entering WAIT_ACK. Also cover a byte arriving in the expiry cycle → byte wins.
- Stream and reset: bytes 0x08, 0x01, 0xFF in IDLE → three stream pulses with those values. Assert reset_n=0 mid-command → all outputs 0, init restarts.
- Init failure: BAT returns 0xFC on every attempt → init_fail=1 after MAX_RETRY+1 attempts; cmd_ready=1.
